// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port (A = ALU, B = load) plus a busy scoreboard.
// Latency: transfer at edge k -> we/wa/wd in cycle k+1. Backpressure: the losing requester sees ready=0 until the pointer favours it.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              we,
    output logic [NREG-1:0]   busy
);

    // r_prio: 0 favours A, 1 favours B
    logic              r_prio;
    logic              r_we;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;
    logic [NREG-1:0]   r_busy;

    logic              w_grant_a;
    logic              w_grant_b;
    logic [NREG-1:0]   w_busy_nxt;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!rst) begin
            w_grant_a = a_valid && (!b_valid || !r_prio);
            w_grant_b = b_valid && (!a_valid ||  r_prio);
        end
    end

    // A reservation landing on the register being written wins: it marks a newer producer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we)
            w_busy_nxt[r_wa] = 1'b0;
        if (rsv_valid)
            w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
            r_we   <= 1'b0;
            r_wa   <= '0;
            r_wd   <= '0;
            r_busy <= '0;
        end else begin
            r_we   <= w_grant_a || w_grant_b;
            r_busy <= w_busy_nxt;
            if (w_grant_a) begin
                r_wa   <= a_addr;
                r_wd   <= a_data;
                r_prio <= 1'b1;
            end else if (w_grant_b) begin
                r_wa   <= b_addr;
                r_wd   <= b_data;
                r_prio <= 1'b0;
            end
        end
    end

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;
    assign we      = r_we;
    assign wa      = r_wa;
    assign wd      = r_wd;
    assign busy    = r_busy;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: grants, write latency, scoreboard and reset behaviour.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, rsv_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_addr, b_addr, rsv_addr;
    logic [31:0] a_data, b_data;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [7:0]  busy;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(3), .NREG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .wa        (wa),
        .wd        (wd),
        .we        (we),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 3'd0; a_data = 32'h0;
        b_valid = 1'b1; b_addr = 3'd0; b_data = 32'h0;
        rsv_valid = 1'b1; rsv_addr = 3'd7;
        #1;

        // 1. Reset with all requests asserted
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
            chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
            tick();
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
        #1;
        chk("rst_we",   {31'b0, we}, 32'd0);
        chk("rst_busy", {24'b0, busy}, 32'h00);
        chk("rst_wa",   {29'b0, wa}, 32'd0);
        chk("rst_wd",   wd, 32'd0);

        // 2. Single A write
        a_valid = 1'b1; a_addr = 3'd2; a_data = 32'h1;
        #1;
        chk("single_a_ready", {31'b0, a_ready}, 32'd1);
        chk("single_b_ready", {31'b0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("single_we", {31'b0, we}, 32'd1);
        chk("single_wa", {29'b0, wa}, 32'd2);
        chk("single_wd", wd, 32'h00000001);
        tick();
        chk("single_we_off", {31'b0, we}, 32'd0);
        chk("single_wa_hold", {29'b0, wa}, 32'd2);

        // 3. Contention from a fresh reset: A,B,A,B,A,B
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1; a_addr = 3'd1; a_data = 32'hFFFFFFFF;
        b_valid = 1'b1; b_addr = 3'd3; b_data = 32'h5;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_a_ready", {31'b0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_b_ready", {31'b0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i > 0) begin
                chk("cont_we", {31'b0, we}, 32'd1);
                chk("cont_wa", {29'b0, wa}, (i % 2 == 1) ? 32'd1 : 32'd3);
                chk("cont_wd", wd, (i % 2 == 1) ? 32'hFFFFFFFF : 32'h5);
            end
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("cont_last_we", {31'b0, we}, 32'd1);
        chk("cont_last_wa", {29'b0, wa}, 32'd3);
        chk("cont_last_wd", wd, 32'h5);
        tick();
        chk("cont_idle_we", {31'b0, we}, 32'd0);

        // 4. Scoreboard set then clear via B write
        rsv_valid = 1'b1; rsv_addr = 3'd4;
        tick();
        rsv_valid = 1'b0;
        chk("sb_set", {24'b0, busy}, 32'h10);
        b_valid = 1'b1; b_addr = 3'd4; b_data = 32'h7;
        #1;
        chk("sb_b_ready", {31'b0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        chk("sb_we", {31'b0, we}, 32'd1);
        chk("sb_wa", {29'b0, wa}, 32'd4);
        chk("sb_wd", wd, 32'h7);
        chk("sb_busy_pending", {24'b0, busy}, 32'h10);
        tick();
        chk("sb_clear", {24'b0, busy}, 32'h00);

        // 5. Set wins over clear on the same register; different registers both apply
        rsv_valid = 1'b1; rsv_addr = 3'd4;
        tick();
        rsv_valid = 1'b0;
        b_valid = 1'b1; b_addr = 3'd4; b_data = 32'h9;
        tick();
        b_valid = 1'b0;
        chk("col_we", {31'b0, we}, 32'd1);
        chk("col_wa", {29'b0, wa}, 32'd4);
        rsv_valid = 1'b1; rsv_addr = 3'd4;
        tick();
        rsv_valid = 1'b0;
        chk("col_set_wins", {24'b0, busy}, 32'h10);
        b_valid = 1'b1; b_addr = 3'd4; b_data = 32'hA;
        tick();
        b_valid = 1'b0;
        chk("col2_we", {31'b0, we}, 32'd1);
        rsv_valid = 1'b1; rsv_addr = 3'd5;
        tick();
        rsv_valid = 1'b0;
        chk("col2_busy", {24'b0, busy}, 32'h20);

        // 6. Reset mid-operation, with prio pointing at B beforehand
        rsv_valid = 1'b1; rsv_addr = 3'd2;
        tick();
        rsv_valid = 1'b0;
        chk("mid_busy_pre", {24'b0, busy}, 32'h24);
        a_valid = 1'b1; a_addr = 3'd0; a_data = 32'h3;
        tick();
        a_addr = 3'd6; a_data = 32'hAB;
        rst = 1'b1;
        #1;
        chk("mid_rst_a_ready", {31'b0, a_ready}, 32'd0);
        tick();
        rst = 1'b0; a_valid = 1'b0;
        #1;
        chk("mid_we", {31'b0, we}, 32'd0);
        chk("mid_busy", {24'b0, busy}, 32'h00);
        a_valid = 1'b1; a_addr = 3'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 3'd3; b_data = 32'h22;
        #1;
        chk("mid_first_a", {31'b0, a_ready}, 32'd1);
        chk("mid_first_b", {31'b0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("mid_wa", {29'b0, wa}, 32'd1);
        chk("mid_wd", wd, 32'h11);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
